// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: one access at a time over a little-endian byte-lane RAM.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned half/word accesses on rsp_err instead of executing them.
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_stall
);

  localparam int         IDX_W     = $clog2(MEM_DEPTH);
  localparam int         AW        = IDX_W + 2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] count_reg, count_next;
  logic       accept;
  logic       enter_resp;

  logic          we_reg;
  logic [1:0]    size_reg;
  logic          unsigned_reg;
  logic [AW-1:0] addr_reg;
  logic [31:0]   wdata_reg;

  logic             op_we;
  logic [1:0]       op_size;
  logic [AW-1:0]    op_addr;
  logic [31:0]      op_wdata;
  logic [IDX_W-1:0] op_idx;
  logic             op_misaligned;

  logic [3:0]  lane_we;
  logic [31:0] lane_wdata;
  logic [31:0] rd_word;
  logic [31:0] load_data;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        rsp_valid_reg;
  logic        err_reg;

  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[DATA_WIDTH-1:AW];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= S_IDLE;
      count_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    req_ready  = (state_reg == S_IDLE);
    mem_stall  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        mem_stall = req_valid;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
            count_next = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        mem_stall  = 1'b1;
        count_next = count_reg - 4'd1;
        if (count_reg == 4'd1) state_next = S_RESP;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the acceptance edge, so the
  // operation is taken straight from the ports while still in IDLE.
  assign enter_resp = (state_next == S_RESP) && !RST;
  assign op_we      = (state_reg == S_IDLE) ? req_we           : we_reg;
  assign op_size    = (state_reg == S_IDLE) ? req_size         : size_reg;
  assign op_addr    = (state_reg == S_IDLE) ? req_addr[AW-1:0] : addr_reg;
  assign op_wdata   = (state_reg == S_IDLE) ? req_wdata        : wdata_reg;
  assign op_idx     = op_addr[AW-1:2];

  always_ff @(posedge CLK) begin
    if (accept) begin
      we_reg       <= req_we;
      size_reg     <= req_size;
      unsigned_reg <= req_unsigned;
      addr_reg     <= req_addr[AW-1:0];
      wdata_reg    <= req_wdata;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign op_misaligned = ((op_size == 2'b01) && op_addr[0]) ||
                         (op_size[1] && (op_addr[1:0] != 2'b00));
`else
  assign op_misaligned = 1'b0;
`endif

  always_comb begin
    lane_we    = 4'b0000;
    lane_wdata = op_wdata;
    case (op_size)
      2'b00: begin
        lane_we[op_addr[1:0]] = 1'b1;
        lane_wdata            = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        lane_we    = op_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{op_wdata[15:0]}};
      end
      default: lane_we = 4'b1111;
    endcase
    if (!(enter_resp && op_we && !op_misaligned)) lane_we = 4'b0000;
  end

  // One byte-wide RAM per lane; the write and the registered read both
  // happen on the edge entering RESP.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [MEM_DEPTH];
      logic [7:0] rd_reg;

      always_ff @(posedge CLK) begin
        if (lane_we[gi]) mem[op_idx] <= lane_wdata[8*gi +: 8];
        if (enter_resp)  rd_reg      <= mem[op_idx];
      end

      assign rd_word[8*gi +: 8] = rd_reg;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      rsp_valid_reg <= enter_resp;
      err_reg       <= enter_resp && op_misaligned;
    end
  end

  always_comb begin
    sel_byte = rd_word[7:0];
    case (addr_reg[1:0])
      2'd1:    sel_byte = rd_word[15:8];
      2'd2:    sel_byte = rd_word[23:16];
      2'd3:    sel_byte = rd_word[31:24];
      default: sel_byte = rd_word[7:0];
    endcase
    sel_half  = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    case (size_reg)
      2'b00:   load_data = {{24{~unsigned_reg & sel_byte[7]}}, sel_byte};
      2'b01:   load_data = {{16{~unsigned_reg & sel_half[15]}}, sel_half};
      default: load_data = rd_word;
    endcase
  end

  // Response data depends only on registered state, and is zero outside
  // the RESP cycle, for stores and for flagged accesses.
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = err_reg;
  assign rsp_rdata = (rsp_valid_reg && !we_reg && !err_reg) ? load_data : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (default parameters, WAIT_CYCLES = 2).
// Expectations follow DMEM_ALIGN_CHECK_EN when the bench is built with it.
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_stall;

  int vec_cnt   = 0;
  int err_cnt   = 0;
  int cycle_cnt = 0;

  dmem_responder dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_stall    (mem_stall)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Starts just after a rising edge; returns just after the edge that ends RESP.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int stalls, output int acc_cycle, output logic post_valid);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    rdata = 32'hxxxx_xxxx; err = 1'bx; lat = 99; stalls = 0;
    @(negedge CLK);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge CLK);
    if (mem_stall) stalls++;
    acc_cycle = cycle_cnt;
    @(posedge CLK); #1;
    // Scramble the ports: the latched request must be used from here on.
    req_valid = 1'b0; req_we = ~we; req_size = ~size; req_unsigned = ~uns;
    req_addr = addr ^ 32'hFFFF_FFFF; req_wdata = ~wdata;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (mem_stall) stalls++;
      if (rsp_valid) begin
        lat = i; rdata = rsp_rdata; err = rsp_err;
        break;
      end
    end
    @(posedge CLK); #1;
    post_valid = rsp_valid;
  endtask

  task automatic test_reset();
    RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid: got %b want 0", rsp_valid); end
    vec_cnt++; if (rsp_rdata !== 32'h0) begin err_cnt++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
    vec_cnt++; if (rsp_err !== 1'b0) begin err_cnt++; $display("FAIL rst_err: got %b want 0", rsp_err); end
    vec_cnt++; if (mem_stall !== 1'b0) begin err_cnt++; $display("FAIL rst_stall_idle: got %b want 0", mem_stall); end
    req_valid = 1'b1; #1;
    vec_cnt++; if (mem_stall !== 1'b1) begin err_cnt++; $display("FAIL stall_comb: got %b want 1", mem_stall); end
    req_valid = 1'b0;
    @(posedge CLK); #1;
    $display("reset: ready=%b valid=%b rdata=%h", req_ready, rsp_valid, rsp_rdata);
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er, pv; int lat, st, ac;
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, st, ac, pv);
    $display("store word @10 = deadbeef: lat=%0d stalls=%0d rdata=%h err=%b", lat, st, rd, er);
    vec_cnt++; if (lat !== 3) begin err_cnt++; $display("FAIL st_lat: got %0d want 3", lat); end
    vec_cnt++; if (st !== 3) begin err_cnt++; $display("FAIL st_stalls: got %0d want 3", st); end
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL st_rdata: got %h want 0", rd); end
    vec_cnt++; if (er !== 1'b0) begin err_cnt++; $display("FAIL st_err: got %b want 0", er); end
    vec_cnt++; if (pv !== 1'b0) begin err_cnt++; $display("FAIL st_one_cycle: got %b want 0", pv); end
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, st, ac, pv);
    $display("load word @10: lat=%0d stalls=%0d rdata=%h", lat, st, rd);
    vec_cnt++; if (lat !== 3) begin err_cnt++; $display("FAIL ld_lat: got %0d want 3", lat); end
    vec_cnt++; if (st !== 3) begin err_cnt++; $display("FAIL ld_stalls: got %0d want 3", st); end
    vec_cnt++; if (rd !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL ld_word: got %h want deadbeef", rd); end
    vec_cnt++; if (pv !== 1'b0 || rsp_rdata !== 32'h0) begin err_cnt++; $display("FAIL ld_after: got %b/%h want 0/0", pv, rsp_rdata); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er, pv; int lat, st, ac;
    access(1'b1, 2'b00, 1'b0, 32'h11, 32'hABCDEF80, rd, er, lat, st, ac, pv);
    access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd, er, lat, st, ac, pv);
    $display("load sbyte @11: rdata=%h", rd);
    vec_cnt++; if (rd !== 32'hFFFFFF80) begin err_cnt++; $display("FAIL lb_signed: got %h want ffffff80", rd); end
    access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, rd, er, lat, st, ac, pv);
    $display("load ubyte @11: rdata=%h", rd);
    vec_cnt++; if (rd !== 32'h00000080) begin err_cnt++; $display("FAIL lb_unsigned: got %h want 00000080", rd); end
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, st, ac, pv);
    $display("load word @10: rdata=%h", rd);
    vec_cnt++; if (rd !== 32'hDEAD80EF) begin err_cnt++; $display("FAIL sb_merge: got %h want dead80ef", rd); end
    access(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, er, lat, st, ac, pv);
    $display("load sbyte @10: rdata=%h", rd);
    vec_cnt++; if (rd !== 32'hFFFFFFEF) begin err_cnt++; $display("FAIL lb_lane0: got %h want ffffffef", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er, pv; int lat, st, ac;
    access(1'b1, 2'b01, 1'b0, 32'h12, 32'h55551234, rd, er, lat, st, ac, pv);
    access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, er, lat, st, ac, pv);
    $display("load shalf @12: rdata=%h", rd);
    vec_cnt++; if (rd !== 32'h00001234) begin err_cnt++; $display("FAIL lh_hi: got %h want 00001234", rd); end
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, st, ac, pv);
    $display("load word @10: rdata=%h", rd);
    vec_cnt++; if (rd !== 32'h123480EF) begin err_cnt++; $display("FAIL sh_merge: got %h want 123480ef", rd); end
    access(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, rd, er, lat, st, ac, pv);
    $display("load shalf @10: rdata=%h", rd);
    vec_cnt++; if (rd !== 32'hFFFF80EF) begin err_cnt++; $display("FAIL lh_signed: got %h want ffff80ef", rd); end
    access(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, rd, er, lat, st, ac, pv);
    $display("load uhalf @10: rdata=%h", rd);
    vec_cnt++; if (rd !== 32'h000080EF) begin err_cnt++; $display("FAIL lh_unsigned: got %h want 000080ef", rd); end
    access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er, lat, st, ac, pv);
    $display("load ubyte @13: rdata=%h", rd);
    vec_cnt++; if (rd !== 32'h00000012) begin err_cnt++; $display("FAIL lb_lane3: got %h want 00000012", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er, pv; int lat, st, ac;
    access(1'b1, 2'b10, 1'b0, 32'h800, 32'hA5A5A5A5, rd, er, lat, st, ac, pv);
    access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, er, lat, st, ac, pv);
    $display("store @800, load @0: rdata=%h", rd);
    vec_cnt++; if (rd !== 32'hA5A5A5A5) begin err_cnt++; $display("FAIL wrap: got %h want a5a5a5a5", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd0, rd1; logic er, pv; int lat, st, ac0, ac1;
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd0, er, lat, st, ac0, pv);
    access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd1, er, lat, st, ac1, pv);
    $display("back-to-back loads: spacing=%0d rdata=%h,%h", ac1 - ac0, rd0, rd1);
    vec_cnt++; if (ac1 - ac0 !== 4) begin err_cnt++; $display("FAIL b2b_spacing: got %0d want 4", ac1 - ac0); end
    vec_cnt++; if (rd0 !== 32'h123480EF) begin err_cnt++; $display("FAIL b2b_first: got %h want 123480ef", rd0); end
    vec_cnt++; if (rd1 !== 32'h00001234) begin err_cnt++; $display("FAIL b2b_second: got %h want 00001234", rd1); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er, pv; int lat, st, ac; logic seen;
    access(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rd, er, lat, st, ac, pv);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h1;
    @(negedge CLK);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(negedge CLK);
    vec_cnt++; if (req_ready !== 1'b0 || mem_stall !== 1'b1) begin err_cnt++; $display("FAIL wait_flags: got ready=%b stall=%b want 0/1", req_ready, mem_stall); end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL mid_rst_ready: got %b want 1", req_ready); end
    seen = rsp_valid;
    repeat (6) begin
      @(negedge CLK);
      if (rsp_valid) seen = 1'b1;
    end
    vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_rsp: got %b want 0", seen); end
    @(posedge CLK); #1;
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat, st, ac, pv);
    $display("reset during store: word @20 = %h", rd);
    vec_cnt++; if (rd !== 32'h11223344) begin err_cnt++; $display("FAIL mid_rst_mem: got %h want 11223344", rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er, pv; int lat, st, ac;
    logic [31:0] exp_word, exp_half, exp_odd;
    logic exp_err;
`ifdef DMEM_ALIGN_CHECK_EN
    exp_err = 1'b1; exp_word = 32'h11223344; exp_half = 32'h0; exp_odd = 32'h0;
`else
    exp_err = 1'b0; exp_word = 32'hCAFEF00D; exp_half = 32'h0000F00D; exp_odd = 32'hCAFEF00D;
`endif
    access(1'b1, 2'b10, 1'b0, 32'h22, 32'hCAFEF00D, rd, er, lat, st, ac, pv);
    $display("store word @22: err=%b rdata=%h lat=%0d", er, rd, lat);
    vec_cnt++; if (er !== exp_err) begin err_cnt++; $display("FAIL mis_st_err: got %b want %b", er, exp_err); end
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL mis_st_rdata: got %h want 0", rd); end
    vec_cnt++; if (lat !== 3) begin err_cnt++; $display("FAIL mis_lat: got %0d want 3", lat); end
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat, st, ac, pv);
    $display("load word @20: rdata=%h err=%b", rd, er);
    vec_cnt++; if (rd !== exp_word) begin err_cnt++; $display("FAIL mis_mem: got %h want %h", rd, exp_word); end
    vec_cnt++; if (er !== 1'b0) begin err_cnt++; $display("FAIL aligned_err: got %b want 0", er); end
    access(1'b0, 2'b10, 1'b0, 32'h23, 32'h0, rd, er, lat, st, ac, pv);
    $display("load word @23: rdata=%h err=%b", rd, er);
    vec_cnt++; if (rd !== exp_odd || er !== exp_err) begin err_cnt++; $display("FAIL mis_lw: got %h/%b want %h/%b", rd, er, exp_odd, exp_err); end
    access(1'b0, 2'b01, 1'b1, 32'h21, 32'h0, rd, er, lat, st, ac, pv);
    $display("load uhalf @21: rdata=%h err=%b", rd, er);
    vec_cnt++; if (rd !== exp_half || er !== exp_err) begin err_cnt++; $display("FAIL mis_lh: got %h/%b want %h/%b", rd, er, exp_half, exp_err); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data and address width; only 32 is supported.
REQ-002 Parameter MEM_DEPTH, default 512: number of 32-bit words in the data array; must be a power of two.
REQ-003 Parameter WAIT_CYCLES, default 2: wait states between request acceptance and the response; allowed range 0..15.
REQ-004 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  memory-stage access request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 req_unsigned  input  1  loads only: 1 zero-extends, 0 sign-extends.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-justified.
REQ-012 req_ready  output  1  responder can accept a request.
REQ-013 rsp_valid  output  1  one-cycle response strobe.
REQ-014 rsp_rdata  output  32  extended load data; 0 for stores.
REQ-015 rsp_err  output  1  misaligned access flag, qualified by rsp_valid.
REQ-016 mem_stall  output  1  pipeline freeze request to the hazard unit.

Function
REQ-017 FSM states: IDLE, WAIT, RESP. req_ready = (state == IDLE).
REQ-018 A request is accepted when req_valid and req_ready are both 1; at acceptance the block latches we, size, unsigned, addr and wdata, and ignores the input ports until it returns to IDLE.
REQ-019 On acceptance the FSM goes to WAIT with the counter loaded to WAIT_CYCLES; if WAIT_CYCLES = 0 it goes directly to RESP.
REQ-020 In WAIT the counter decrements once per cycle; the FSM moves to RESP on the cycle the counter reaches 1.
REQ-021 RESP lasts exactly one cycle with rsp_valid = 1, then the FSM returns to IDLE. Latency from acceptance edge to rsp_valid is WAIT_CYCLES+1 cycles. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
REQ-022 mem_stall = (state == IDLE && req_valid) || state == WAIT; it is combinational and low during RESP.
REQ-023 Word index = latched addr[log2(MEM_DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*MEM_DEPTH.
REQ-024 Byte order is little-endian.
  - Byte store writes lane addr[1:0] with wdata[7:0].
  - Half store writes lanes {addr[1],1} and {addr[1],0} with wdata[15:0].
  - Word store writes all four lanes.
  - Unwritten lanes are preserved.
REQ-025 Store data is committed to the array on the edge entering RESP; a load in RESP to the same word returns the updated data.
REQ-026 Load data is the selected lane or half, extended to 32 bits per req_unsigned; a word load returns the word unchanged. rsp_rdata is registered and is 0 whenever rsp_valid = 0.
REQ-027 A response for a store carries rsp_rdata = 0 and rsp_err = 0 (except misalignment per REQ-031).

Reset
REQ-028 While RST = 1 at a clock edge: state <= IDLE, counter <= 0, rsp_valid <= 0, rsp_rdata <= 0, rsp_err <= 0; any pending store is discarded.
REQ-029 Reset does not clear the memory array.
REQ-030 A reset asserted mid-operation (WAIT or RESP) produces no response; req_ready = 1 in the first cycle after reset is released.

Configuration
REQ-031 With macro DMEM_ALIGN_CHECK_EN defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, performs no write, returns rsp_rdata = 0 with rsp_err = 1, and keeps the normal latency.
REQ-032 Without DMEM_ALIGN_CHECK_EN: rsp_err is tied 0; a half access ignores addr[0] and a word access ignores addr[1:0].

Verification
REQ-033 WAIT_CYCLES = 2, word store 0xDEADBEEF to 0x10, then word load from 0x10 -> rsp_valid 3 cycles after each acceptance; load returns 0xDEADBEEF; mem_stall is high for 3 cycles per access.
REQ-034 Byte store 0x80 to 0x11, then signed byte load from 0x11 and unsigned byte load from 0x11 -> 0xFFFFFF80 and 0x00000080; word at 0x10 reads 0xDEAD80EF.
REQ-035 Half store 0x1234 to 0x12, then signed half load from 0x12 -> 0x00001234; word at 0x10 reads 0x123480EF.
REQ-036 MEM_DEPTH = 512, word store 0xA5A5A5A5 to 0x800, then load from 0x0 -> 0xA5A5A5A5 (wrap-around).
REQ-037 Assert RST during WAIT of a store of 0x1 to 0x20 -> no rsp_valid; the word at 0x20 is unchanged; req_ready = 1 the cycle after RST falls.
REQ-038 With DMEM_ALIGN_CHECK_EN, word store to 0x22 -> rsp_err = 1, rsp_rdata = 0, memory unchanged. Without the macro, the same store writes the word at 0x20.
